// File: rtl/instr_sequencer.sv
// Instruction fetch/issue sequencer for the practical-6 CPU: walks instruction
// memory from address 0 and holds each instruction for its class-specific dwell.
module instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5,
    parameter int LAST_ADDR   = 31
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic [PC_BITS-1:0]     imem_addr_o,
    input  logic [INSTR_WIDTH-1:0] imem_data_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_BITS-1:0]     pc_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [7:0]             retired_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                   state_q;
    logic [INSTR_WIDTH-1:0]   instr_q;
    logic [PC_BITS-1:0]       pc_q;
    logic [PC_BITS-1:0]       pcInc_d;
    logic [2:0]               dc_q;
    logic [7:0]               retired_q;
    logic                     busy_q;
    logic                     done_q;
    logic [1:0]               fetchClass_d;
    logic                     isLast_d;

    // Number of control-unit sampling edges each instruction class occupies.
    function automatic logic [2:0] dwellOf(input logic [1:0] cls);
        case (cls)
            2'b01:   dwellOf = 3'd3;
            2'b10:   dwellOf = 3'd4;
            2'b11:   dwellOf = 3'd3;
            default: dwellOf = 3'd0;
        endcase
    endfunction

    assign fetchClass_d = imem_data_i[INSTR_WIDTH-1 -: 2];
    assign pcInc_d      = pc_q + 1'b1;
    assign isLast_d     = (pc_q == PC_BITS'(LAST_ADDR));

    // Prefetch the next word during RUN so it is ready by the time dc reaches 1.
    always_comb begin
        imem_addr_o = '0;
        case (state_q)
            RUN:     imem_addr_o = pcInc_d;
            DONE:    imem_addr_o = pc_q;
            default: imem_addr_o = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            pc_q      <= '0;
            dc_q      <= '0;
            retired_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    instr_q <= '0;
                    if (start_i) begin
                        pc_q      <= '0;
                        retired_q <= '0;
                        if (fetchClass_d != 2'b00) begin
                            // Extra edge covers the control unit's RESET->DECODE step.
                            instr_q <= imem_data_i;
                            dc_q    <= dwellOf(fetchClass_d) + 3'd1;
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    dc_q <= dc_q - 3'd1;
                    if (dc_q == 3'd1) begin
                        retired_q <= retired_q + 8'd1;
                        if (isLast_d || fetchClass_d == 2'b00) begin
                            instr_q <= '0;
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            instr_q <= imem_data_i;
                            pc_q    <= pcInc_d;
                            dc_q    <= dwellOf(fetchClass_d);
                        end
                    end
                end
                DONE: begin
                    instr_q <= '0;
                end
                default: begin
                    state_q   <= IDLE;
                    instr_q   <= '0;
                    pc_q      <= '0;
                    dc_q      <= '0;
                    retired_q <= '0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign retired_o = retired_q;

endmodule
